// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to 4-digit BCD converter.
// One iteration per clock; fixed latency of BIN_WIDTH OP cycles plus one
// DONE cycle. Digits wrap modulo 10000 (carry out of thousands dropped).
// Optional macro BIN_TO_BCD_SAT_EN: when defined, inputs above 9999 saturate
// the display to 9999 and raise overflow; when undefined overflow is tied 0.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 ready,
    output logic                 done_tick,
    output logic [3:0]           bcd_out [0:3],
    output logic                 overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [15:0]          r_digits;
    logic [3:0]           r_bcd [0:3];
    logic                 r_ready;
    logic                 r_done;

    // Digits after the add-3 correction. The thousands digit keeps only its
    // low three bits: its top bit would shift out and is deliberately lost.
    logic [14:0]          w_adj;
    logic [15:0]          w_digits_nxt;
    logic [BIN_WIDTH-1:0] w_shift_nxt;
    logic                 w_last;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // One double-dabble step: correct every digit, then shift the whole
    // {digits, shift register} chain left by one.
    always_comb begin
        w_adj        = {3'(add3(r_digits[15:12])), add3(r_digits[11:8]),
                        add3(r_digits[7:4]), add3(r_digits[3:0])};
        w_digits_nxt = {w_adj, r_shift[BIN_WIDTH-1]};
        w_shift_nxt  = r_shift << 1;
        w_last       = (r_cnt == CNT_W'(1));
    end

`ifdef BIN_TO_BCD_SAT_EN
    logic r_big;
    logic r_overflow;
    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    // Control FSM, datapath and registered outputs in one sequential block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_digits <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            for (int i = 0; i < 4; i++) r_bcd[i] <= 4'd0;
`ifdef BIN_TO_BCD_SAT_EN
            r_big      <= 1'b0;
            r_overflow <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (start) begin
                        r_shift  <= bin;
                        r_digits <= '0;
                        r_cnt    <= CNT_W'(BIN_WIDTH);
                        r_ready  <= 1'b0;
                        r_state  <= S_OP;
`ifdef BIN_TO_BCD_SAT_EN
                        r_big    <= (32'(bin) > 32'd9999);
`endif
                    end
                end
                S_OP: begin
                    r_digits <= w_digits_nxt;
                    r_shift  <= w_shift_nxt;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        // Final iteration: publish its result directly so the
                        // outputs are valid during the DONE cycle itself.
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
`ifdef BIN_TO_BCD_SAT_EN
                            r_bcd[i] <= r_big ? 4'd9 : w_digits_nxt[4*i +: 4];
`else
                            r_bcd[i] <= w_digits_nxt[4*i +: 4];
`endif
                        end
`ifdef BIN_TO_BCD_SAT_EN
                        r_overflow <= r_big;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign done_tick = r_done;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign bcd_out[g] = r_bcd[g];
    end

endmodule
